// File: rtl/aud_pkg.sv
// Shared audio-path definitions: default widths and the recorder state encoding.
// Used by the recorder, the player and the DSP blocks.
package aud_pkg;

   localparam int unsigned AUD_ADDR_W   = 20;
   localparam int unsigned AUD_SAMPLE_W = 16;
   localparam logic [AUD_ADDR_W-1:0] AUD_ADDR_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_SKIP,
      S_SHIFT,
      S_STORE,
      S_PAUSE
   } rec_state_e;

endpackage

// File: rtl/aud_recorder_i2s_rx_shift.sv
// Serial-to-parallel shifter for one I2S channel word, MSB first.
// The bit counter restarts whenever the enable drops, so an aborted word leaves no residue.
module i2s_rx_shift
   import aud_pkg::*;
#(
   parameter int unsigned SAMPLE_W = AUD_SAMPLE_W
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_en,
   input  logic                i_data,
   output logic [SAMPLE_W-1:0] o_sample,
   output logic                o_last
);

   localparam int unsigned CNT_W = $clog2(SAMPLE_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SAMPLE_W-1:0] shift_reg;
   logic [CNT_W-1:0]    bit_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else if (i_en) begin
         shift_reg <= {shift_reg[SAMPLE_W-2:0], i_data};
         bit_cnt   <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_ONE;
      end else begin
         bit_cnt   <= '0;
      end
   end

   assign o_sample = shift_reg;
   assign o_last   = i_en && (bit_cnt == CNT_LAST);

endmodule

// File: rtl/aud_recorder.sv
// I2S ADC receiver: captures left-channel samples and streams them to SRAM
// at incrementing addresses, with record / pause / stop control.
module aud_recorder
   import aud_pkg::*;
#(
   parameter int unsigned           ADDR_W   = AUD_ADDR_W,
   parameter int unsigned           SAMPLE_W = AUD_SAMPLE_W,
   parameter logic [ADDR_W-1:0]     ADDR_MAX = '1
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_lrc,
   input  logic                i_data,
   input  logic                i_start,
   input  logic                i_pause,
   input  logic                i_stop,
   output logic [ADDR_W-1:0]   o_address,
   output logic [SAMPLE_W-1:0] o_data,
   output logic                o_valid,
   output logic [ADDR_W:0]     o_length,
   output logic                o_full,
   output logic                o_busy
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

   rec_state_e          state;
   rec_state_e          state_nxt;
   logic                lrc_q;
   logic                frame_start;
   logic                pause_pend;
   logic                shift_en;
   logic                shift_last;
   logic                at_max;
   logic [SAMPLE_W-1:0] sample;

   assign frame_start = !i_lrc && lrc_q;
   assign at_max      = (o_address == ADDR_MAX);

   i2s_rx_shift #(
      .SAMPLE_W (SAMPLE_W)
   ) u_shift (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (shift_en),
      .i_data   (i_data),
      .o_sample (sample),
      .o_last   (shift_last)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Priority on coincident pulses is stop, then pause, then start.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (i_start && !i_stop && !i_pause) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_stop) begin
               state_nxt = S_IDLE;
            end else if (i_pause || pause_pend) begin
               state_nxt = S_PAUSE;
            end else if (frame_start) begin
               state_nxt = S_SKIP;
            end
         end
         S_SKIP: begin
            state_nxt = i_stop ? S_IDLE : S_SHIFT;
         end
         S_SHIFT: begin
            if (i_stop) begin
               state_nxt = S_IDLE;
            end else if (shift_last) begin
               state_nxt = S_STORE;
            end
         end
         S_STORE: begin
            if (i_stop || at_max) begin
               state_nxt = S_IDLE;
            end else if (i_pause || pause_pend) begin
               state_nxt = S_PAUSE;
            end else begin
               state_nxt = S_WAIT;
            end
         end
         S_PAUSE: begin
            if (i_stop) begin
               state_nxt = S_IDLE;
            end else if (i_start && !i_pause) begin
               state_nxt = S_WAIT;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_valid  = (state == S_STORE);
      o_busy   = (state != S_IDLE);
      shift_en = (state == S_SHIFT);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lrc_q      <= 1'b1;
         pause_pend <= 1'b0;
         o_address  <= '0;
         o_length   <= '0;
         o_full     <= 1'b0;
         o_data     <= '0;
      end else begin
         lrc_q <= i_lrc;

         if (state_nxt == S_PAUSE || state_nxt == S_IDLE) begin
            pause_pend <= 1'b0;
         end else if (i_pause && (state == S_WAIT || state == S_SKIP ||
                                  state == S_SHIFT || state == S_STORE)) begin
            pause_pend <= 1'b1;
         end

         if (state == S_IDLE && state_nxt == S_WAIT) begin
            o_address <= '0;
            o_length  <= '0;
            o_full    <= 1'b0;
         end else if (state == S_STORE) begin
            o_length <= o_length + LEN_ONE;
            if (at_max) begin
               o_full <= 1'b1;
            end else begin
               o_address <= o_address + ADDR_ONE;
            end
         end

         // Load the word including the bit arriving on the final shift edge,
         // so the complete sample is presented alongside the write strobe.
         if (shift_last) begin
            o_data <= {sample[SAMPLE_W-2:0], i_data};
         end
      end
   end

endmodule

// File: tb/tb_aud_recorder.sv
// Scoreboard bench for aud_recorder: frame driver pushes expected writes,
// a negedge monitor pops and compares every write strobe.
module tb_aud_recorder;

   localparam int unsigned AW = 4;
   localparam int unsigned SW = 16;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [SW-1:0] data;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          lrc;
   logic          data;
   logic          start;
   logic          pause;
   logic          stop;
   logic [AW-1:0] o_address;
   logic [SW-1:0] o_data;
   logic          o_valid;
   logic [AW:0]   o_length;
   logic          o_full;
   logic          o_busy;

   int   checks   = 0;
   int   failures = 0;
   int   pcount   = 0;
   int   fall_pc  = 0;
   exp_t sb[$];
   exp_t mon_e;

   aud_recorder #(
      .ADDR_W   (AW),
      .SAMPLE_W (SW)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_lrc     (lrc),
      .i_data    (data),
      .i_start   (start),
      .i_pause   (pause),
      .i_stop    (stop),
      .o_address (o_address),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .o_length  (o_length),
      .o_full    (o_full),
      .o_busy    (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) pcount++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (o_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write", o_address, o_data);
         end else begin
            mon_e = sb.pop_front();
            chk("write_data", 32'(o_data), 32'(mon_e.data));
            chk("write_addr", 32'(o_address), 32'(mon_e.addr));
            chk("write_latency", 32'(pcount - fall_pc), 32'd18);
         end
      end
   end

   // One channel period: delay bit, skipped bit, then SW data bits MSB first.
   task automatic frame(input logic lr, input logic [SW-1:0] s, input int len,
                        input int pause_at, input int stop_at);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (stop_at >= 0 && i == stop_at + 1) chk("stop_busy_next", 32'(o_busy), 32'd0);
         lrc   = lr;
         data  = (i >= 2 && i < 18) ? s[17 - i] : 1'b0;
         pause = (i == pause_at);
         stop  = (i == stop_at);
         if (i == 0 && lr == 1'b0) fall_pc = pcount;
      end
      pause = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic pair(input logic [SW-1:0] s);
      frame(1'b0, s, 32, -1, -1);
      frame(1'b1, 16'hFFFF, 32, -1, -1);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      lrc   = 1'b1;
      data  = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      stop  = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_address", 32'(o_address), 32'd0);
      chk("rst_data",    32'(o_data),    32'd0);
      chk("rst_valid",   32'(o_valid),   32'd0);
      chk("rst_length",  32'(o_length),  32'd0);
      chk("rst_full",    32'(o_full),    32'd0);
      chk("rst_busy",    32'(o_busy),    32'd0);

      // Single sample
      pulse_start();
      chk("start_busy", 32'(o_busy), 32'd1);
      sb.push_back('{addr: 4'd0, data: 16'hA5C3});
      frame(1'b0, 16'hA5C3, 32, -1, -1);
      chk("single_addr", 32'(o_address), 32'd1);
      chk("single_len",  32'(o_length),  32'd1);

      // Right channel ignored
      frame(1'b1, 16'hFFFF, 32, -1, -1);
      sb.push_back('{addr: 4'd1, data: 16'h0001});
      frame(1'b0, 16'h0001, 32, -1, -1);
      frame(1'b1, 16'hFFFF, 32, -1, -1);
      chk("right_len", 32'(o_length), 32'd2);

      // Pause during bit 7: sample still written, then no writes until resume
      sb.push_back('{addr: 4'd2, data: 16'h1234});
      frame(1'b0, 16'h1234, 32, 9, -1);
      frame(1'b1, 16'hFFFF, 32, -1, -1);
      chk("pause_addr", 32'(o_address), 32'd3);
      chk("pause_busy", 32'(o_busy), 32'd1);
      pair(16'h1111);
      pair(16'h2222);
      pair(16'h3333);
      chk("pause_len_hold", 32'(o_length), 32'd3);
      pulse_start();
      sb.push_back('{addr: 4'd3, data: 16'h8001});
      pair(16'h8001);
      chk("resume_addr", 32'(o_address), 32'd4);
      chk("resume_len",  32'(o_length),  32'd4);

      // Stop during bit 10: partial sample discarded
      frame(1'b0, 16'hBEEF, 32, -1, 12);
      frame(1'b1, 16'hFFFF, 32, -1, -1);
      chk("stop_len",  32'(o_length),  32'd4);
      chk("stop_addr", 32'(o_address), 32'd4);
      chk("stop_busy", 32'(o_busy),    32'd0);
      pair(16'h7777);

      // Fill all 16 addresses
      pulse_start();
      chk("restart_addr", 32'(o_address), 32'd0);
      chk("restart_len",  32'(o_length),  32'd0);
      for (int k = 0; k < 16; k++) begin
         sb.push_back('{addr: 4'(k), data: 16'(16'h1000 + k * 273)});
         pair(16'(16'h1000 + k * 273));
      end
      chk("full_flag", 32'(o_full),    32'd1);
      chk("full_len",  32'(o_length),  32'd16);
      chk("full_addr", 32'(o_address), 32'd15);
      chk("full_busy", 32'(o_busy),    32'd0);
      pair(16'hDEAD);

      // Async reset in the middle of a sample
      pulse_start();
      chk("full_cleared", 32'(o_full), 32'd0);
      sb.push_back('{addr: 4'd0, data: 16'h5A5A});
      pair(16'h5A5A);
      frame(1'b0, 16'hC0DE, 11, -1, -1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_address", 32'(o_address), 32'd0);
      chk("arst_data",    32'(o_data),    32'd0);
      chk("arst_valid",   32'(o_valid),   32'd0);
      chk("arst_length",  32'(o_length),  32'd0);
      chk("arst_full",    32'(o_full),    32'd0);
      chk("arst_busy",    32'(o_busy),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      frame(1'b0, 16'hC0DE, 21, -1, -1);
      frame(1'b1, 16'hFFFF, 32, -1, -1);
      pair(16'h4321);
      chk("arst_idle_busy", 32'(o_busy), 32'd0);

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
